// File: rtl/bcd_conv.sv
// bcd_conv: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// A write (bcd_cs && bcd_write) captures a 16-bit value. Sixteen shift
// cycles then produce five BCD digits. Those digits are committed to the
// display outputs in a single step.
// Writes that arrive while busy go to a one-deep pending buffer, where the
// latest write wins. Overwriting a buffered value sets the sticky bcd_drop flag.
// Optional feature macro: BCD_BLANK_EN adds the bcd_blank leading-zero mask.
module bcd_conv #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  bcd_clk,
    input  logic                  bcd_rst_n,
    input  logic [DATA_W-1:0]     bcd_wdata,
    input  logic                  bcd_cs,
    input  logic                  bcd_write,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic [2:0]            bcd_ndigits,
    output logic                  bcd_busy,
    output logic                  bcd_done,
    output logic                  bcd_drop
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     bcd_blank
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]            state;
    logic [DATA_W-1:0]     bin;
    logic [4*DIGITS-1:0]   bcd;
    logic [3:0]            cnt;
    logic                  pend_valid;
    logic [DATA_W-1:0]     pend_data;

    logic                  wr;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS+DATA_W-1:0] shifted;
    logic [2:0]            nd_next;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank_next;
`endif

    assign wr = bcd_cs && bcd_write;

    // Add-3 correction on every nibble >= 5, then one left shift of {bcd, bin}
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[4*DIGITS-2:0], bin, 1'b0};
    end

    // Significant digit count: position of the highest nonzero nibble plus one
    always_comb begin
        nd_next = 3'd1;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                nd_next = 3'(i + 1);
            end
        end
    end

`ifdef BCD_BLANK_EN
    // Leading-zero mask: bit i set when nibble i and everything above it is zero
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        blank_next  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (bcd[4*i +: 4] == 4'd0);
            blank_next[i] = higher_zero;
        end
    end
`endif

    // Control FSM, shift engine, pending buffer and committed display outputs
    always_ff @(posedge bcd_clk or negedge bcd_rst_n) begin
        if (!bcd_rst_n) begin
            state       <= IDLE;
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            bcd_digits  <= '0;
            bcd_ndigits <= 3'd1;
            bcd_busy    <= 1'b0;
            bcd_done    <= 1'b0;
            bcd_drop    <= 1'b0;
`ifdef BCD_BLANK_EN
            bcd_blank   <= 5'b11110;
`endif
        end else begin
            bcd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr) begin
                        bin      <= bcd_wdata;
                        bcd      <= '0;
                        cnt      <= '0;
                        bcd_busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= shifted[4*DIGITS+DATA_W-1:DATA_W];
                    bin <= shifted[DATA_W-1:0];
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= COMMIT;
                    end
                    if (wr) begin
                        pend_data  <= bcd_wdata;
                        pend_valid <= 1'b1;
                        if (pend_valid) begin
                            bcd_drop <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    bcd_digits  <= bcd;
                    bcd_ndigits <= nd_next;
                    bcd_done    <= 1'b1;
`ifdef BCD_BLANK_EN
                    bcd_blank   <= blank_next;
`endif
                    pend_valid  <= 1'b0;
                    if (wr || pend_valid) begin
                        // A write on this edge supersedes any buffered value.
                        bin      <= wr ? bcd_wdata : pend_data;
                        bcd      <= '0;
                        cnt      <= '0;
                        bcd_busy <= 1'b1;
                        state    <= SHIFT;
                        if (wr && pend_valid) begin
                            bcd_drop <= 1'b1;
                        end
                    end else begin
                        bcd_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bcd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
